stg1if_fq: RTL

- Parametrised fetch stage. Successor to the single-entry PC/instruction latch.
- Captures (pc, instr) pairs returned by instruction memory into a DEPTH-entry FIFO and presents the head entry to decode with a valid/stall handshake.
- Adds back-pressure toward memory, pipeline flush, and overflow detection.
- Sits between the instruction memory port and stage 2 (decode).

---
 rtl/stg1if_fq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/stg1if_fq.sv
// -----------------------------------------------------------------------------
// stg1if_fq -- fetch-stage instruction queue
//
// Buffers (pc, instr) pairs returned by instruction memory in a DEPTH-entry
// register FIFO and presents the oldest entry to decode. Decode consumes the
// head whenever it is valid and not stalled. Memory is throttled with
// ow_mem_ready (not full). A push attempted while full is dropped and latches
// the sticky ow_ovf flag. iw_flush empties the queue on a branch or redirect.
// Every output is driven only from registered state.
//
// Ports
//   iw_clk        clock, all state updates on the rising edge
//   iw_rst        asynchronous active-high reset
//   iw_mem_valid  memory presents a fetched word this cycle
//   iw_mem_data   fetched instruction word
//   iw_pc         address of iw_mem_data
//   ow_mem_ready  queue can accept a push (not full)
//   iw_stall      decode is not accepting; the head is held
//   iw_flush      discard all queued entries
//   ow_valid      head entry valid
//   ow_pc         head entry PC (0 when empty)
//   ow_instr      head entry instruction (0 when empty)
//   ow_count      current occupancy, 0..DEPTH
//   ow_ovf        sticky: push attempted while full
// -----------------------------------------------------------------------------
module stg1if_fq #(
  parameter  int ADDR_W = 24,
  parameter  int DATA_W = 24,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_mem_valid,
  input  logic [DATA_W-1:0] iw_mem_data,
  input  logic [ADDR_W-1:0] iw_pc,
  output logic              ow_mem_ready,
  input  logic              iw_stall,
  input  logic              iw_flush,
  output logic              ow_valid,
  output logic [ADDR_W-1:0] ow_pc,
  output logic [DATA_W-1:0] ow_instr,
  output logic [CNT_W-1:0]  ow_count,
  output logic              ow_ovf
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Storage: one PC and one instruction word per entry.
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;

  logic not_empty;
  logic not_full;
  logic push;
  logic pop;

  // Status comes from the occupancy register alone, so neither ow_valid nor
  // ow_mem_ready can form a combinational path from any input.
  assign not_empty = (count != '0);
  assign not_full  = (count != FULL_CNT);

  // Push and pop are both judged on the state before the edge. A pop while
  // full therefore does not open a slot for a push in the same cycle.
  assign push = iw_mem_valid && not_full;
  assign pop  = not_empty && !iw_stall;

  // Pointers, occupancy and the overflow flag. Flush takes priority over any
  // push, pop or overflow event in the same cycle.
  // NOTE: sequential state is assigned with <= so that every register samples
  // its pre-edge value and the outcome does not depend on statement order.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (iw_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (iw_mem_valid && !not_full) ovf <= 1'b1;
    end
  end

  // Entry storage. The array has no reset: an entry is never observed before
  // it is written, because the head is masked to zero while the queue is empty.
  // NOTE: leaving the storage array out of reset keeps it a plain register file
  // with a clock-enable, instead of DEPTH words of reset-muxed flops.
  always_ff @(posedge iw_clk) begin
    if (push && !iw_flush) begin
      pc_mem[wr_ptr]    <= iw_pc;
      instr_mem[wr_ptr] <= iw_mem_data;
    end
  end

  // Head presentation, forced to zero while the queue is empty.
  assign ow_valid     = not_empty;
  assign ow_mem_ready = not_full;
  assign ow_pc        = not_empty ? pc_mem[rd_ptr]    : '0;
  assign ow_instr     = not_empty ? instr_mem[rd_ptr] : '0;
  assign ow_count     = count;
  assign ow_ovf       = ovf;

endmodule
